// File: rtl/result_sram_reader.sv
// Streams num_words consecutive result-SRAM words out on a valid/ready port.
// An output register plus a small queue absorbs the 1-cycle SRAM read latency.
module result_sram_reader #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_words,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
   input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   // state  | meaning
   // IDLE   | waiting for start; a zero-length start only pulses done
   // READ   | issuing reads whenever credit allows
   // DRAIN  | all reads issued; waiting for the last word to handshake

   localparam int Q_DEPTH = FIFO_DEPTH - 1;
   localparam int Q_PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   next_addr_q;
   logic [ADDR_W-1:0]   remaining_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                inflight_q;
   logic                inflight_last_q;
   logic                done_q;

   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic                out_last_q;

   logic [DATA_W-1:0]   q_data [Q_DEPTH];
   logic [Q_DEPTH-1:0]  q_last;
   logic [Q_PTR_W-1:0]  q_wr_ptr, q_rd_ptr;
   logic [CNT_W-1:0]    q_count;

   logic                pop, issue, accept, zero_start, final_hs;
   logic                load_out, q_pop, q_push, direct;
   logic [CNT_W-1:0]    credit_used;

   function automatic logic [Q_PTR_W-1:0] ptr_inc(input logic [Q_PTR_W-1:0] p);
      return (p == Q_PTR_W'(Q_DEPTH - 1)) ? '0 : p + Q_PTR_W'(1);
   endfunction

   assign pop = out_valid_q && out_ready;

   // A word leaving this cycle frees its slot in time for the read issued now.
   assign credit_used = q_count + CNT_W'(out_valid_q) + CNT_W'(inflight_q) - CNT_W'(pop);

   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      accept     = 1'b0;
      zero_start = 1'b0;
      final_hs   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_words != '0) begin
                  accept  = 1'b1;
                  state_d = S_READ;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         S_READ: begin
            if (credit_used < CNT_W'(FIFO_DEPTH)) begin
               issue = 1'b1;
               if (remaining_q == ADDR_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && out_last_q) begin
               final_hs = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         next_addr_q     <= '0;
         remaining_q     <= '0;
         rd_addr_q       <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         done_q          <= zero_start || final_hs;
         inflight_q      <= issue;
         inflight_last_q <= issue && (remaining_q == ADDR_W'(1));
         if (accept) begin
            next_addr_q <= base_addr;
            remaining_q <= num_words;
         end else if (issue) begin
            rd_addr_q   <= next_addr_q;
            next_addr_q <= next_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
         end
      end
   end

   // Output register is the FIFO head; the queue behind it holds the rest.
   assign load_out = !out_valid_q || pop;
   assign q_pop    = load_out && (q_count != '0);
   assign direct   = load_out && (q_count == '0) && inflight_q;
   assign q_push   = inflight_q && !direct;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         q_last      <= '0;
         q_wr_ptr    <= '0;
         q_rd_ptr    <= '0;
         q_count     <= '0;
      end else begin
         if (load_out) begin
            if (q_count != '0) begin
               out_valid_q <= 1'b1;
               out_data_q  <= q_data[q_rd_ptr];
               out_last_q  <= q_last[q_rd_ptr];
            end else if (inflight_q) begin
               out_valid_q <= 1'b1;
               out_data_q  <= tb__dut__sram_result_read_data;
               out_last_q  <= inflight_last_q;
            end else begin
               out_valid_q <= 1'b0;
            end
         end
         if (q_push) begin
            q_last[q_wr_ptr] <= inflight_last_q;
            q_wr_ptr         <= ptr_inc(q_wr_ptr);
         end
         if (q_pop) q_rd_ptr <= ptr_inc(q_rd_ptr);
         case ({q_push, q_pop})
            2'b10:   q_count <= q_count + CNT_W'(1);
            2'b01:   q_count <= q_count - CNT_W'(1);
            default: q_count <= q_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (q_push) q_data[q_wr_ptr] <= tb__dut__sram_result_read_data;
   end

   assign busy                              = (state_q != S_IDLE);
   assign done                              = done_q;
   assign dut__tb__sram_result_read_address = rd_addr_q;
   assign out_valid                         = out_valid_q;
   assign out_data                          = out_data_q;
   assign out_last                          = out_last_q && out_valid_q;

endmodule

// File: tb/tb_result_sram_reader.sv
// Directed bench for result_sram_reader: SRAM word at address a reads as a+100.
module tb_result_sram_reader;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] num_words;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   result_sram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
      .clk                               (clk),
      .reset                             (reset),
      .start                             (start),
      .base_addr                         (base_addr),
      .num_words                         (num_words),
      .busy                              (busy),
      .done                              (done),
      .dut__tb__sram_result_read_address (rd_addr),
      .tb__dut__sram_result_read_data    (rd_data),
      .out_valid                         (out_valid),
      .out_data                          (out_data),
      .out_last                          (out_last),
      .out_ready                         (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rd_data = {16'h0, rd_addr} + 32'd100;

   // Handshake log, done counter and stall-stability monitor, sampled mid-cycle.
   logic [DATA_W:0]   hs_q [$];
   int                done_cnt   = 0;
   int                stall_viol = 0;
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stall_viol++;
         if (out_last && !out_valid) stall_viol++;
         if (out_valid && out_ready) hs_q.push_back({out_last, out_data});
         if (done) done_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
      start     = 1'b1;
      base_addr = b;
      num_words = n;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
      n_tests++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
      n_tests++; if (rd_addr !== 16'h0)  begin n_fail++; $display("FAIL reset_addr: got %h want 0", rd_addr); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_normal();
      logic        ev [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
      logic        el [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      logic        ed [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      logic        eb [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic [31:0] dd [8] = '{0, 0, 100, 101, 102, 103, 103, 103};
      out_ready = 1'b1;
      pulse_start(16'h0000, 16'd4);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         n_tests++; if (out_valid !== ev[k]) begin n_fail++; $display("FAIL normal_valid[%0d]: got %b want %b", k, out_valid, ev[k]); end
         n_tests++; if (out_last !== el[k])  begin n_fail++; $display("FAIL normal_last[%0d]: got %b want %b", k, out_last, el[k]); end
         n_tests++; if (done !== ed[k])      begin n_fail++; $display("FAIL normal_done[%0d]: got %b want %b", k, done, ed[k]); end
         n_tests++; if (busy !== eb[k])      begin n_fail++; $display("FAIL normal_busy[%0d]: got %b want %b", k, busy, eb[k]); end
         if (k >= 2) begin
            n_tests++; if (out_data !== dd[k]) begin n_fail++; $display("FAIL normal_data[%0d]: got %0d want %0d", k, out_data, dd[k]); end
         end
      end
      n_tests++; if (rd_addr !== 16'd3) begin n_fail++; $display("FAIL normal_addr_end: got %h want 0003", rd_addr); end
   endtask

   task automatic test_zero_length();
      int d0  = done_cnt;
      int hs0 = hs_q.size();
      out_ready = 1'b1;
      pulse_start(16'h0055, 16'd0);
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 1", done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
      for (int k = 0; k < 5; k++) tick();
      n_tests++; if (done_cnt - d0 !== 1)        begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
      n_tests++; if (hs_q.size() - hs0 !== 0)    begin n_fail++; $display("FAIL zero_handshakes: got %0d want 0", hs_q.size() - hs0); end
      n_tests++; if (rd_addr !== 16'd3)          begin n_fail++; $display("FAIL zero_no_read: addr got %h want 0003", rd_addr); end
      n_tests++; if (out_data !== 32'd103)       begin n_fail++; $display("FAIL zero_data_hold: got %0d want 103", out_data); end
   endtask

   task automatic test_wrap();
      logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      logic [31:0] ew [4] = '{32'h0001_0062, 32'h0001_0063, 32'd100, 32'd101};
      int hs0 = hs_q.size();
      int d0  = done_cnt;
      out_ready = 1'b1;
      pulse_start(16'hFFFE, 16'd4);
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++; if (rd_addr !== ea[k]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, rd_addr, ea[k]); end
      end
      for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
      n_tests++;
      if (hs_q.size() - hs0 !== 4) begin
         n_fail++; $display("FAIL wrap_count: got %0d want 4", hs_q.size() - hs0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++; if (hs_q[hs0+k] !== {(k == 3), ew[k]}) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", k, hs_q[hs0+k], {(k == 3), ew[k]}); end
         end
      end
   endtask

   task automatic test_backpressure();
      int hs0 = hs_q.size();
      int d0  = done_cnt;
      int v0  = stall_viol;
      out_ready = 1'b0;
      pulse_start(16'h0020, 16'd6);
      for (int k = 0; k < 8; k++) tick();
      n_tests++; if (rd_addr !== 16'h0021) begin n_fail++; $display("FAIL bp_credit_stop: addr got %h want 0021", rd_addr); end
      n_tests++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", out_valid); end
      n_tests++; if (out_data !== 32'd132) begin n_fail++; $display("FAIL bp_data_held: got %0d want 132", out_data); end
      for (int i = 0; i < 60 && done_cnt == d0; i++) begin
         out_ready = ~out_ready;
         tick();
      end
      out_ready = 1'b1;
      tick();
      n_tests++; if (done_cnt - d0 !== 1)     begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt - d0); end
      n_tests++; if (stall_viol - v0 !== 0)   begin n_fail++; $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol - v0); end
      n_tests++;
      if (hs_q.size() - hs0 !== 6) begin
         n_fail++; $display("FAIL bp_count: got %0d want 6", hs_q.size() - hs0);
      end else begin
         for (int k = 0; k < 6; k++) begin
            n_tests++; if (hs_q[hs0+k] !== {(k == 5), 32'(132 + k)}) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", k, hs_q[hs0+k], {(k == 5), 32'(132 + k)}); end
         end
      end
   endtask

   task automatic test_ignored_start();
      int hs0 = hs_q.size();
      int d0  = done_cnt;
      out_ready = 1'b1;
      pulse_start(16'h0040, 16'd5);
      tick();
      tick();
      pulse_start(16'h0080, 16'd2);
      for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
      for (int k = 0; k < 6; k++) tick();
      n_tests++; if (done_cnt - d0 !== 1)   begin n_fail++; $display("FAIL ign_done: got %0d want 1", done_cnt - d0); end
      n_tests++; if (rd_addr !== 16'h0044)  begin n_fail++; $display("FAIL ign_addr: got %h want 0044", rd_addr); end
      n_tests++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL ign_busy: got %b want 0", busy); end
      n_tests++;
      if (hs_q.size() - hs0 !== 5) begin
         n_fail++; $display("FAIL ign_count: got %0d want 5", hs_q.size() - hs0);
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_tests++; if (hs_q[hs0+k] !== {(k == 4), 32'(164 + k)}) begin n_fail++; $display("FAIL ign_word[%0d]: got %h want %h", k, hs_q[hs0+k], {(k == 4), 32'(164 + k)}); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int hs0, d0;
      out_ready = 1'b0;
      pulse_start(16'h0010, 16'd8);
      for (int k = 0; k < 5; k++) tick();
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      tick();
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      n_tests++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
      n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_no_resume: got %b want 0", out_valid); end
      n_tests++; if (rd_addr !== 16'h0)   begin n_fail++; $display("FAIL rstmid_addr: got %h want 0000", rd_addr); end
      hs0 = hs_q.size();
      d0  = done_cnt;
      pulse_start(16'h0000, 16'd2);
      for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
      n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rstmid_restart_done: got %0d want 1", done_cnt - d0); end
      n_tests++;
      if (hs_q.size() - hs0 !== 2) begin
         n_fail++; $display("FAIL rstmid_restart_count: got %0d want 2", hs_q.size() - hs0);
      end else begin
         n_tests++; if (hs_q[hs0] !== {1'b0, 32'd100})   begin n_fail++; $display("FAIL rstmid_word0: got %h want %h", hs_q[hs0], {1'b0, 32'd100}); end
         n_tests++; if (hs_q[hs0+1] !== {1'b1, 32'd101}) begin n_fail++; $display("FAIL rstmid_word1: got %h want %h", hs_q[hs0+1], {1'b1, 32'd101}); end
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      num_words = '0;
      out_ready = 1'b0;
      test_reset();
      test_normal();
      test_zero_length();
      test_wrap();
      test_backpressure();
      test_ignored_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
